// File: rtl/nested_ii_counter.sv
// rtl/nested_ii_counter.sv - Nested loop index generator with initiation-interval pacing
//
// Purpose: walks a DEPTH-level loop nest (level 0 innermost). It issues one
// iteration every II ticks, and the first iteration is issued in the start
// cycle itself.
//
// Ports:
//   clk      in   clock, all state updates on posedge
//   rst      in   synchronous active-high reset, wins over start_i
//   start_i  in   begin a new nest (aborts any nest in progress)
//   adv_i    in   tick qualifier when MODE = 1, ignored when MODE = 0
//   trip_i   in   per-level trip counts, level k at [k*WIDTH +: WIDTH]
//   valid_o  out  an iteration is issued this cycle
//   idx_o    out  per-level index of the issued iteration, packed like trip_i
//   last_o   out  the issued iteration is the final one of the nest
//   busy_o   out  a nest is in progress (including the start cycle)
//   done_o   out  one-cycle pulse after a nest completes
module nested_ii_counter #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    parameter int II    = 1,
    parameter int MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   adv_i,
    input  logic [DEPTH*WIDTH-1:0] trip_i,
    output logic                   valid_o,
    output logic [DEPTH*WIDTH-1:0] idx_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [15:0] PHASE_MAX = 16'(II - 1);

    state_t                 state_q, state_d;
    logic [DEPTH*WIDTH-1:0] trip_q, trip_d;
    logic [DEPTH*WIDTH-1:0] idx_q, idx_d;
    logic [15:0]            phase_q, phase_d;
    logic                   done_q, done_d;

    logic [DEPTH*WIDTH-1:0] idx_inc;
    logic                   inc_last;
    logic                   trip_zero;
    logic                   trip_one;
    logic                   tick;
    logic                   start_eff;
    logic                   phase_wrap;

    assign tick       = (MODE == 0) || adv_i;
    assign start_eff  = start_i && !rst;
    assign phase_wrap = (phase_q == PHASE_MAX);

    // Odometer-style increment of the held index; inc_last flags that the
    // incremented index is trip-1 on every level.
    always_comb begin : incrementer
        logic             carry;
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] lim;
        logic [WIDTH-1:0] nxt;
        carry    = 1'b1;
        cur      = '0;
        lim      = '0;
        nxt      = '0;
        idx_inc  = idx_q;
        inc_last = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            cur = idx_q[k*WIDTH +: WIDTH];
            lim = trip_q[k*WIDTH +: WIDTH] - WIDTH'(1);
            nxt = cur;
            if (carry) begin
                if (cur == lim) begin
                    nxt = '0;
                end else begin
                    nxt   = cur + WIDTH'(1);
                    carry = 1'b0;
                end
            end
            idx_inc[k*WIDTH +: WIDTH] = nxt;
            if (nxt != lim) begin
                inc_last = 1'b0;
            end
        end
    end

    // Classification of the incoming trip counts, used only on start.
    always_comb begin : trip_check
        trip_zero = 1'b0;
        trip_one  = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (trip_i[k*WIDTH +: WIDTH] == '0) begin
                trip_zero = 1'b1;
            end
            if (trip_i[k*WIDTH +: WIDTH] != WIDTH'(1)) begin
                trip_one = 1'b0;
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        trip_d  = trip_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        valid_o = 1'b0;
        idx_o   = idx_q;
        last_o  = 1'b0;
        busy_o  = (state_q == RUN);
        if (start_eff) begin
            // start overrides any tick and silently drops a finishing nest
            busy_o = 1'b1;
            trip_d = trip_i;
            if (trip_zero) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                idx_d   = '0;
                phase_d = '0;
                valid_o = 1'b1;
                idx_o   = '0;
                last_o  = trip_one;
                // an all-ones nest finishes in its start cycle
                if (trip_one) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
        end else if (state_q == RUN && tick) begin
            phase_d = phase_wrap ? 16'd0 : phase_q + 16'd1;
            if (phase_wrap) begin
                valid_o = 1'b1;
                idx_o   = idx_inc;
                idx_d   = idx_inc;
                last_o  = inc_last;
                if (inc_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            trip_q  <= '0;
            idx_q   <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trip_q  <= trip_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_nested_ii_counter.sv
// tb/tb_nested_ii_counter.sv - Directed self-checking bench for nested_ii_counter
module tb_nested_ii_counter;

    logic clk;
    logic rst;

    // u_a: DEPTH=2, II=1, MODE 0
    logic        a_start, a_adv, a_valid, a_last, a_busy, a_done;
    logic [31:0] a_trip, a_idx;
    // u_b: DEPTH=1, II=3, MODE 0
    logic        b_start, b_adv, b_valid, b_last, b_busy, b_done;
    logic [15:0] b_trip, b_idx;
    // u_c: DEPTH=1, II=2, MODE 1
    logic        c_start, c_adv, c_valid, c_last, c_busy, c_done;
    logic [15:0] c_trip, c_idx;

    int n_checks = 0;
    int n_fail   = 0;

    nested_ii_counter #(.DEPTH(2), .WIDTH(16), .II(1), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .start_i(a_start), .adv_i(a_adv), .trip_i(a_trip),
        .valid_o(a_valid), .idx_o(a_idx), .last_o(a_last), .busy_o(a_busy), .done_o(a_done)
    );

    nested_ii_counter #(.DEPTH(1), .WIDTH(16), .II(3), .MODE(0)) u_b (
        .clk(clk), .rst(rst), .start_i(b_start), .adv_i(b_adv), .trip_i(b_trip),
        .valid_o(b_valid), .idx_o(b_idx), .last_o(b_last), .busy_o(b_busy), .done_o(b_done)
    );

    nested_ii_counter #(.DEPTH(1), .WIDTH(16), .II(2), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .start_i(c_start), .adv_i(c_adv), .trip_i(c_trip),
        .valid_o(c_valid), .idx_o(c_idx), .last_o(c_last), .busy_o(c_busy), .done_o(c_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %b exp 0", a_valid); end
        n_checks++; if (a_idx !== 32'h0) begin n_fail++; $display("FAIL reset_a_idx got %h exp 0", a_idx); end
        n_checks++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL reset_a_last got %b exp 0", a_last); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_a_busy got %b exp 0", a_busy); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_a_done got %b exp 0", a_done); end
        n_checks++; if (b_busy !== 1'b0 || b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b got busy %b valid %b exp 0 0", b_busy, b_valid); end
        n_checks++; if (c_idx !== 16'h0 || c_done !== 1'b0) begin n_fail++; $display("FAIL reset_c got idx %h done %b exp 0 0", c_idx, c_done); end
    endtask

    task automatic test_nest2();
        logic [7:0]  ev = 8'b0011_1111;
        logic [7:0]  el = 8'b0010_0000;
        logic [7:0]  ed = 8'b0100_0000;
        logic [7:0]  eb = 8'b0011_1111;
        logic [31:0] ei [8] = '{32'h00000000, 32'h00000001, 32'h00010000, 32'h00010001,
                                32'h00020000, 32'h00020001, 32'h00020001, 32'h00020001};
        a_trip = 32'h0003_0002;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a_start = (c == 0);
            if (c == 2) a_trip = 32'h0009_0009;
            #2;
            n_checks++; if (a_valid !== ev[c]) begin n_fail++; $display("FAIL nest2_valid c=%0d got %b exp %b", c, a_valid, ev[c]); end
            n_checks++; if (a_idx !== ei[c]) begin n_fail++; $display("FAIL nest2_idx c=%0d got %h exp %h", c, a_idx, ei[c]); end
            n_checks++; if (a_last !== el[c]) begin n_fail++; $display("FAIL nest2_last c=%0d got %b exp %b", c, a_last, el[c]); end
            n_checks++; if (a_done !== ed[c]) begin n_fail++; $display("FAIL nest2_done c=%0d got %b exp %b", c, a_done, ed[c]); end
            n_checks++; if (a_busy !== eb[c]) begin n_fail++; $display("FAIL nest2_busy c=%0d got %b exp %b", c, a_busy, eb[c]); end
        end
    endtask

    task automatic test_zero_trip();
        logic [3:0] ed = 4'b0010;
        logic [3:0] eb = 4'b0001;
        a_trip = 32'h0000_0005;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            a_start = (c == 0);
            #2;
            n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid c=%0d got %b exp 0", c, a_valid); end
            n_checks++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL zero_last c=%0d got %b exp 0", c, a_last); end
            n_checks++; if (a_done !== ed[c]) begin n_fail++; $display("FAIL zero_done c=%0d got %b exp %b", c, a_done, ed[c]); end
            n_checks++; if (a_busy !== eb[c]) begin n_fail++; $display("FAIL zero_busy c=%0d got %b exp %b", c, a_busy, eb[c]); end
        end
    endtask

    task automatic test_single();
        logic [2:0] ev = 3'b001;
        logic [2:0] ed = 3'b010;
        a_trip = 32'h0001_0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a_start = (c == 0);
            #2;
            n_checks++; if (a_valid !== ev[c]) begin n_fail++; $display("FAIL single_valid c=%0d got %b exp %b", c, a_valid, ev[c]); end
            n_checks++; if (a_last !== ev[c]) begin n_fail++; $display("FAIL single_last c=%0d got %b exp %b", c, a_last, ev[c]); end
            n_checks++; if (a_busy !== ev[c]) begin n_fail++; $display("FAIL single_busy c=%0d got %b exp %b", c, a_busy, ev[c]); end
            n_checks++; if (a_done !== ed[c]) begin n_fail++; $display("FAIL single_done c=%0d got %b exp %b", c, a_done, ed[c]); end
            n_checks++; if (a_idx !== 32'h0) begin n_fail++; $display("FAIL single_idx c=%0d got %h exp 0", c, a_idx); end
        end
    endtask

    task automatic test_restart();
        logic [7:0]  ev = 8'b0011_1111;
        logic [7:0]  el = 8'b0010_0000;
        logic [7:0]  ed = 8'b0100_0000;
        logic [31:0] ei [8] = '{32'h0, 32'h1, 32'h0, 32'h1, 32'h2, 32'h3, 32'h3, 32'h3};
        a_trip = 32'h0001_0004;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a_start = (c == 0) || (c == 2);
            #2;
            n_checks++; if (a_valid !== ev[c]) begin n_fail++; $display("FAIL restart_valid c=%0d got %b exp %b", c, a_valid, ev[c]); end
            n_checks++; if (a_idx !== ei[c]) begin n_fail++; $display("FAIL restart_idx c=%0d got %h exp %h", c, a_idx, ei[c]); end
            n_checks++; if (a_last !== el[c]) begin n_fail++; $display("FAIL restart_last c=%0d got %b exp %b", c, a_last, el[c]); end
            n_checks++; if (a_done !== ed[c]) begin n_fail++; $display("FAIL restart_done c=%0d got %b exp %b", c, a_done, ed[c]); end
            n_checks++; if (a_busy !== ev[c]) begin n_fail++; $display("FAIL restart_busy c=%0d got %b exp %b", c, a_busy, ev[c]); end
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0]  ev = 8'b0000_0111;
        logic [31:0] ei [8] = '{32'h0, 32'h1, 32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        a_trip = 32'h0003_0002;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a_start = (c == 0);
            rst = (c == 3);
            #2;
            if (c != 3) begin
                n_checks++; if (a_valid !== ev[c]) begin n_fail++; $display("FAIL rstmid_valid c=%0d got %b exp %b", c, a_valid, ev[c]); end
                n_checks++; if (a_busy !== ev[c]) begin n_fail++; $display("FAIL rstmid_busy c=%0d got %b exp %b", c, a_busy, ev[c]); end
                n_checks++; if (a_idx !== ei[c]) begin n_fail++; $display("FAIL rstmid_idx c=%0d got %h exp %h", c, a_idx, ei[c]); end
                n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done c=%0d got %b exp 0", c, a_done); end
            end
        end
    endtask

    task automatic test_ii3();
        logic [5:0]  ev = 6'b00_1001;
        logic [5:0]  el = 6'b00_1000;
        logic [5:0]  ed = 6'b01_0000;
        logic [5:0]  eb = 6'b00_1111;
        logic [15:0] ei [6] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
        b_trip = 16'd2;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            b_start = (c == 0);
            #2;
            n_checks++; if (b_valid !== ev[c]) begin n_fail++; $display("FAIL ii3_valid c=%0d got %b exp %b", c, b_valid, ev[c]); end
            n_checks++; if (b_idx !== ei[c]) begin n_fail++; $display("FAIL ii3_idx c=%0d got %h exp %h", c, b_idx, ei[c]); end
            n_checks++; if (b_last !== el[c]) begin n_fail++; $display("FAIL ii3_last c=%0d got %b exp %b", c, b_last, el[c]); end
            n_checks++; if (b_done !== ed[c]) begin n_fail++; $display("FAIL ii3_done c=%0d got %b exp %b", c, b_done, ed[c]); end
            n_checks++; if (b_busy !== eb[c]) begin n_fail++; $display("FAIL ii3_busy c=%0d got %b exp %b", c, b_busy, eb[c]); end
        end
    endtask

    task automatic test_start_on_last();
        logic [8:0]  ev = 9'b0_0100_1001;
        logic [8:0]  el = 9'b0_0100_0000;
        logic [8:0]  ed = 9'b0_1000_0000;
        logic [8:0]  eb = 9'b0_0111_1111;
        logic [15:0] ei [9] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
        b_trip = 16'd2;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            b_start = (c == 0) || (c == 3);
            #2;
            n_checks++; if (b_valid !== ev[c]) begin n_fail++; $display("FAIL sol_valid c=%0d got %b exp %b", c, b_valid, ev[c]); end
            n_checks++; if (b_idx !== ei[c]) begin n_fail++; $display("FAIL sol_idx c=%0d got %h exp %h", c, b_idx, ei[c]); end
            n_checks++; if (b_last !== el[c]) begin n_fail++; $display("FAIL sol_last c=%0d got %b exp %b", c, b_last, el[c]); end
            n_checks++; if (b_done !== ed[c]) begin n_fail++; $display("FAIL sol_done c=%0d got %b exp %b", c, b_done, ed[c]); end
            n_checks++; if (b_busy !== eb[c]) begin n_fail++; $display("FAIL sol_busy c=%0d got %b exp %b", c, b_busy, eb[c]); end
        end
    endtask

    task automatic test_mode1();
        logic [9:0]  ev = 10'b00_1001_0001;
        logic [9:0]  el = 10'b00_1000_0000;
        logic [9:0]  ed = 10'b01_0000_0000;
        logic [9:0]  eb = 10'b00_1111_1111;
        logic [15:0] ei [10] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2};
        c_trip = 16'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            c_start = (c == 0);
            c_adv   = (c == 2) || (c == 4) || (c == 5) || (c == 7) || (c == 8);
            #2;
            n_checks++; if (c_valid !== ev[c]) begin n_fail++; $display("FAIL mode1_valid c=%0d got %b exp %b", c, c_valid, ev[c]); end
            n_checks++; if (c_idx !== ei[c]) begin n_fail++; $display("FAIL mode1_idx c=%0d got %h exp %h", c, c_idx, ei[c]); end
            n_checks++; if (c_last !== el[c]) begin n_fail++; $display("FAIL mode1_last c=%0d got %b exp %b", c, c_last, el[c]); end
            n_checks++; if (c_done !== ed[c]) begin n_fail++; $display("FAIL mode1_done c=%0d got %b exp %b", c, c_done, ed[c]); end
            n_checks++; if (c_busy !== eb[c]) begin n_fail++; $display("FAIL mode1_busy c=%0d got %b exp %b", c, c_busy, eb[c]); end
        end
        c_adv = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        a_start = 1'b0; a_adv = 1'b0; a_trip = '0;
        b_start = 1'b0; b_adv = 1'b0; b_trip = '0;
        c_start = 1'b0; c_adv = 1'b0; c_trip = '0;
        test_reset();
        test_nest2();
        test_zero_trip();
        test_single();
        test_restart();
        test_rst_mid();
        test_ii3();
        test_start_on_last();
        test_mode1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
